ps2_receiver: RTL and testbench

Deserializes the device-to-host PS/2 stream (ps2_clk/ps2_data pins) into validated scan-code bytes. It sits directly upstream of the keyboard buffer FIFO: `wr_data`/`we` connect to the FIFO write port, and `clk` also drives the FIFO's write clock. The block synchronizes and deglitches both pins, frames 11-bit packets, checks odd parity and the stop bit, and aborts stalled frames with a watchdog. Host-to-device transmission is out of scope; both PS/2 pins are inputs only.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 43 ++++
 rtl/ps2_receiver.sv | 148 ++++++++++++++
 tb/tb_ps2_receiver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 device-to-host receiver.
package ps2_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DATA   = 2'd1;
    localparam state_t ST_PARITY = 2'd2;
    localparam state_t ST_STOP   = 2'd3;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

    // Counter width able to hold 0..len.
    function automatic int unsigned filter_cnt_w(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a deglitch filter: the output only follows
// the line after FILTER_LEN consecutive samples that differ from it.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line,
    output logic filtered
);

    localparam int unsigned CNT_W = filter_cnt_w(FILTER_LEN);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            filtered <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            // Any sample agreeing with the output restarts the run.
            if (sync2 != filtered) begin
                if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                    filtered <= sync2;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: frames 11-bit packets from the filtered pins,
// checks odd parity and stop bit, and writes good bytes into the keyboard FIFO.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] wr_data,
    output logic       we,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            filt_clk;
    logic            filt_data;
    logic            clk_q;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      shift;
    logic [7:0]      shift_nxt;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_cnt_nxt;
    logic            par;
    logic            par_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_cnt_nxt;
    logic            we_nxt;
    logic            perr_nxt;
    logic            ferr_nxt;
    logic            load_c;
    logic            fall_c;
    logic            timeout_c;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .line     (ps2_clk),
        .filtered (filt_clk)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .line     (ps2_data),
        .filtered (filt_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            clk_q      <= 1'b1;
            shift      <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            wd_cnt     <= '0;
            wr_data    <= '0;
            we         <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            clk_q      <= filt_clk;
            shift      <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            par        <= par_nxt;
            wd_cnt     <= wd_cnt_nxt;
            we         <= we_nxt;
            parity_err <= perr_nxt;
            frame_err  <= ferr_nxt;
            busy       <= (state_nxt != ST_IDLE);
            if (load_c) begin
                wr_data <= shift;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par;
        wd_cnt_nxt  = wd_cnt;
        we_nxt      = 1'b0;
        perr_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
        load_c      = 1'b0;

        fall_c    = clk_q & ~filt_clk;
        timeout_c = (state != ST_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

        // Watchdog: idle and every detected edge restart it; it saturates otherwise.
        if (fall_c || (state == ST_IDLE)) begin
            wd_cnt_nxt = '0;
        end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
            wd_cnt_nxt = wd_cnt + WD_W'(1);
        end

        if (fall_c) begin
            case (state)
                ST_IDLE: begin
                    if (filt_data == START_BIT) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_nxt   = {filt_data, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_nxt   = filt_data;
                    state_nxt = ST_STOP;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    if (filt_data != STOP_BIT) begin
                        ferr_nxt = 1'b1;
                    end else if (^{shift, par} == 1'b0) begin
                        perr_nxt = 1'b1;
                    end else begin
                        we_nxt = 1'b1;
                        load_c = 1'b1;
                    end
                end
            endcase
        end else if (timeout_c) begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
            shift_nxt = '0;
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: frames are driven on the pins, expected
// pulses are queued at the pin edge that should cause them and matched on output.
module tb_ps2_receiver;

    localparam int unsigned F    = 4;
    localparam int unsigned T    = 200;
    localparam int unsigned HALF = 20;
    localparam int unsigned LAT  = F + 3;

    localparam int K_WE   = 0;
    localparam int K_PERR = 1;
    localparam int K_FERR = 2;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] wr_data;
    logic       we;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         errors    = 0;
    int         checks    = 0;
    int         cyc       = 0;
    int         last_fall = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ps2_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .wr_data    (wr_data),
        .we         (we),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   kind;
        if (reset_n) begin
            if (prev_pulse)
                check("pulse_width", {29'd0, we, parity_err, frame_err}, 32'd0);
            if (we | parity_err | frame_err) begin
                check("onehot", 32'(we) + 32'(parity_err) + 32'(frame_err), 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {29'd0, we, parity_err, frame_err}, 32'd0);
                end else begin
                    e    = sb.pop_front();
                    kind = frame_err ? K_FERR : (parity_err ? K_PERR : K_WE);
                    check("kind", 32'(kind), 32'(e.kind));
                    check("latency", 32'(cyc), 32'(e.cyc));
                    if (e.kind == K_WE) last_good = e.data;
                    check("wr_data", {24'd0, wr_data}, {24'd0, last_good});
                    check("busy_fall", {31'd0, busy}, 32'd0);
                end
            end
        end
        prev_pulse <= we | parity_err | frame_err;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int kind, input logic [7:0] d, input int at_cyc);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.cyc  = at_cyc;
        sb.push_back(e);
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half-period.
    task automatic ps2_bit(input logic b, input bit push, input int kind,
                           input logic [7:0] d, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(5);
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 7);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk   = 1'b0;
        last_fall = cyc;
        if (push) push_exp(kind, d, cyc + LAT);
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int glitch_bit);
        int kind;
        kind = (s == 1'b0) ? K_FERR : ((^{d, p}) ? K_WE : K_PERR);
        ps2_bit(1'b0, 1'b0, 0, 8'h00, 1'b0);
        check("busy_rise", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++)
            ps2_bit(d[i], 1'b0, 0, 8'h00, (i == glitch_bit));
        ps2_bit(p, 1'b0, 0, 8'h00, 1'b0);
        ps2_bit(s, 1'b1, kind, d, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        wait_cyc(3);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        wait_cyc(HALF);

        send_frame(8'h1C, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        send_frame(8'h1C, 1'b1, 1'b0, -1);

        // Stall after five data bits; the watchdog must abort the frame.
        d = 8'h5A;
        ps2_bit(1'b0, 1'b0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(d[i], 1'b0, 0, 8'h00, 1'b0);
        push_exp(K_FERR, 8'h00, last_fall + LAT + T);
        wait_cyc(T + 2 * HALF);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b1, -1);

        send_frame(8'h1C, 1'b0, 1'b1, 3);

        // A clock edge with data high while idle is a bad start bit.
        ps2_bit(1'b1, 1'b1, K_FERR, 8'h00, 1'b0);
        wait_cyc(2 * HALF);

        // Reset in the middle of a frame.
        ps2_bit(1'b0, 1'b0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(d[i], 1'b0, 0, 8'h00, 1'b0);
        reset_n = 1'b0;
        wait_cyc(2);
        check("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("mid_rst_we", {31'd0, we}, 32'd0);
        check("mid_rst_perr", {31'd0, parity_err}, 32'd0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        last_good = 8'h00;
        reset_n   = 1'b1;
        wait_cyc(HALF);
        send_frame(8'h1C, 1'b0, 1'b1, -1);

        wait_cyc(T);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
